// File: rtl/dp_pkg.sv
// Shared types and opcode constants for the DP source/sink link.
package dp_pkg;

  localparam logic [3:0] CTL_PASS_A = 4'd0;
  localparam logic [3:0] CTL_PASS_B = 4'd1;
  localparam logic [3:0] CTL_AND    = 4'd2;
  localparam logic [3:0] CTL_OR     = 4'd3;
  localparam logic [3:0] CTL_ADD    = 4'd4;
  localparam logic [3:0] CTL_SUB    = 4'd5;
  localparam logic [3:0] CTL_SUB_C  = 4'd6;
  localparam logic [3:0] CTL_INC    = 4'd7;
  localparam logic [3:0] CTL_DEC    = 4'd8;
  localparam logic [3:0] CTL_XOR    = 4'd9;
  localparam logic [3:0] CTL_NOT_A  = 4'd10;
  localparam logic [3:0] CTL_SHL    = 4'd11;
  localparam logic [3:0] CTL_SHR    = 4'd12;
  localparam logic [3:0] CTL_ROT_C  = 4'd13;
  localparam logic [3:0] CTL_MAX    = CTL_ROT_C;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    ACTIVE
  } dp_state_e;

  typedef struct packed {
    logic       carry;
    logic [3:0] alu;
    logic       zero;
  } dp_word_t;

  function automatic logic ctl_legal(input logic [3:0] c);
    return (c <= CTL_MAX);
  endfunction

endpackage

// File: rtl/dp_sink_fifo.sv
// Small circular FIFO of captured result words; head is read straight from storage.
module dp_sink_fifo
  import dp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  dp_word_t                 i_data,
  input  logic                     i_pop,
  output dp_word_t                 o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  dp_word_t      r_mem [DEPTH];

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;

  assign w_full  = (r_level == (AW+1)'(DEPTH));
  assign w_empty = (r_level == '0);
  // A pop on empty is ignored; a push on full only lands if a pop frees the slot.
  assign w_pop   = i_pop & ~w_empty;
  assign w_push  = i_push & (~w_full | w_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_level = r_level;

endmodule

// File: rtl/dp_sink.sv
// DP link sink: opcode issue FSM with drain window, valid/zero decode, capture FIFO and fault flags.
module dp_sink
  import dp_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  input  logic [3:0]             cmd_ctl,
  output logic                   cmd_ready,
  output logic [3:0]             ctl,
  input  logic                   rx_valid,
  input  logic [3:0]             rx_alu,
  input  logic                   rx_carry,
  input  logic                   rx_zero,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [3:0]             m_alu,
  output logic                   m_carry,
  output logic                   m_zero,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   ovf,
  output logic                   illegal_ctl,
  output logic                   zero_err
);

  localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  dp_state_e   r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]  r_ctl, w_ctl_nxt;
  logic        r_illegal, w_illegal_nxt;
  logic        r_ovf;
  logic        r_zero_err;

  logic        w_cmd_ready;
  logic        w_cmd_acc;
  logic        w_rx_fire;
  logic        w_push;
  logic        w_full;
  logic        w_empty;
  dp_word_t    w_word;
  dp_word_t    w_head;

  assign w_cmd_ready = (r_state != DRAIN);
  assign w_cmd_acc   = cmd_valid & w_cmd_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_ctl     <= CTL_PASS_A;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_ctl     <= w_ctl_nxt;
      r_illegal <= w_illegal_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_ctl_nxt     = r_ctl;
    w_illegal_nxt = 1'b0;
    case (r_state)
      DRAIN: begin
        if (r_cnt == '0) w_state_nxt = ACTIVE;
        else             w_cnt_nxt   = r_cnt - 1'b1;
      end
      default: begin
        // Re-issuing the current opcode still drains the source pipeline.
        if (w_cmd_acc) begin
          if (ctl_legal(cmd_ctl)) begin
            w_ctl_nxt   = cmd_ctl;
            w_state_nxt = DRAIN;
            w_cnt_nxt   = CW'(DRAIN_CYCLES - 1);
          end else begin
            w_illegal_nxt = 1'b1;
          end
        end
      end
    endcase
  end

  // Source inverts valid in XOR mode; its zero flag means "non-zero", so store the inverse.
  assign w_rx_fire = rx_valid ^ (r_ctl == CTL_XOR);
  assign w_push    = (r_state == ACTIVE) & w_rx_fire;
  assign w_word    = '{carry: rx_carry, alu: rx_alu, zero: ~rx_zero};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovf      <= 1'b0;
      r_zero_err <= 1'b0;
    end else begin
      if (w_push & w_full & ~m_ready)      r_ovf      <= 1'b1;
      if (w_push & (rx_zero != |rx_alu))   r_zero_err <= 1'b1;
    end
  end

  dp_sink_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_word),
    .i_pop   (m_ready),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (fifo_level)
  );

  assign cmd_ready   = w_cmd_ready;
  assign ctl         = r_ctl;
  assign m_valid     = ~w_empty;
  assign m_alu       = w_head.alu;
  assign m_carry     = w_head.carry;
  assign m_zero      = w_head.zero;
  assign ovf         = r_ovf;
  assign illegal_ctl = r_illegal;
  assign zero_err    = r_zero_err;

endmodule

// File: tb/tb_dp_sink.sv
// Directed bench for dp_sink: table-driven cycle vectors plus hand-written corner sequences.
module tb_dp_sink;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic [3:0] cmd_ctl;
  logic       cmd_ready;
  logic [3:0] ctl;
  logic       rx_valid;
  logic [3:0] rx_alu;
  logic       rx_carry;
  logic       rx_zero;
  logic       m_valid;
  logic       m_ready;
  logic [3:0] m_alu;
  logic       m_carry;
  logic       m_zero;
  logic [2:0] fifo_level;
  logic       ovf;
  logic       illegal_ctl;
  logic       zero_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dp_sink #(.DEPTH(4), .DRAIN_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ctl(cmd_ctl), .cmd_ready(cmd_ready), .ctl(ctl),
    .rx_valid(rx_valid), .rx_alu(rx_alu), .rx_carry(rx_carry), .rx_zero(rx_zero),
    .m_valid(m_valid), .m_ready(m_ready), .m_alu(m_alu), .m_carry(m_carry), .m_zero(m_zero),
    .fifo_level(fifo_level), .ovf(ovf), .illegal_ctl(illegal_ctl), .zero_err(zero_err)
  );

  typedef struct {
    logic       cv;
    logic [3:0] cc;
    logic       rv;
    logic [3:0] ra;
    logic       rc;
    logic       rz;
    logic       mr;
    logic       e_mv;
    logic [3:0] e_alu;
    logic       e_carry;
    logic       e_mz;
    int         e_lvl;
    logic [3:0] e_ctl;
    logic       e_crdy;
  } vec_t;

  vec_t tbl [18];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cmd_valid = 0; cmd_ctl = 0; rx_valid = 0; rx_alu = 0;
    rx_carry = 0; rx_zero = 0; m_ready = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    cyc(); cyc();
    reset = 0;
  endtask

  task automatic do_cmd(input logic [3:0] c);
    cmd_valid = 1; cmd_ctl = c;
    cyc();
    cmd_valid = 0;
    cyc(); cyc();
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    #2;
    do_reset();

    chk("rst_ctl", ctl, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_alu", m_alu, 0);
    chk("rst_m_carry", m_carry, 0);
    chk("rst_m_zero", m_zero, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_illegal", illegal_ctl, 0);
    chk("rst_zero_err", zero_err, 0);

    // cv cc rv ra rc rz mr | mv alu carry mz lvl ctl crdy
    tbl[0]  = '{1, 4'd3, 0, 4'd0, 0, 0, 0,  0, 4'd0, 0, 0, 0, 4'd3, 0};
    tbl[1]  = '{0, 4'd0, 0, 4'd0, 0, 0, 0,  0, 4'd0, 0, 0, 0, 4'd3, 0};
    tbl[2]  = '{0, 4'd0, 0, 4'd0, 0, 0, 0,  0, 4'd0, 0, 0, 0, 4'd3, 1};
    tbl[3]  = '{0, 4'd0, 1, 4'd5, 0, 1, 0,  1, 4'd5, 0, 0, 1, 4'd3, 1};
    tbl[4]  = '{0, 4'd0, 1, 4'd0, 0, 0, 0,  1, 4'd5, 0, 0, 2, 4'd3, 1};
    tbl[5]  = '{0, 4'd0, 1, 4'd9, 1, 1, 0,  1, 4'd5, 0, 0, 3, 4'd3, 1};
    tbl[6]  = '{0, 4'd0, 0, 4'd0, 0, 0, 1,  1, 4'd0, 0, 1, 2, 4'd3, 1};
    tbl[7]  = '{0, 4'd0, 0, 4'd0, 0, 0, 1,  1, 4'd9, 1, 0, 1, 4'd3, 1};
    tbl[8]  = '{0, 4'd0, 0, 4'd0, 0, 0, 1,  0, 4'd0, 0, 0, 0, 4'd3, 1};
    tbl[9]  = '{1, 4'd9, 0, 4'd0, 0, 0, 0,  0, 4'd0, 0, 0, 0, 4'd9, 0};
    tbl[10] = '{0, 4'd0, 1, 4'd0, 0, 0, 0,  0, 4'd0, 0, 0, 0, 4'd9, 0};
    tbl[11] = '{0, 4'd0, 1, 4'd0, 0, 0, 0,  0, 4'd0, 0, 0, 0, 4'd9, 1};
    tbl[12] = '{0, 4'd0, 0, 4'hA, 1, 1, 0,  1, 4'hA, 1, 0, 1, 4'd9, 1};
    tbl[13] = '{0, 4'd0, 1, 4'd3, 0, 1, 0,  1, 4'hA, 1, 0, 1, 4'd9, 1};
    tbl[14] = '{0, 4'd0, 1, 4'd0, 0, 0, 1,  0, 4'd0, 0, 0, 0, 4'd9, 1};
    tbl[15] = '{1, 4'd3, 1, 4'd0, 0, 0, 0,  0, 4'd0, 0, 0, 0, 4'd3, 0};
    tbl[16] = '{0, 4'd0, 0, 4'd0, 0, 0, 0,  0, 4'd0, 0, 0, 0, 4'd3, 0};
    tbl[17] = '{0, 4'd0, 0, 4'd0, 0, 0, 0,  0, 4'd0, 0, 0, 0, 4'd3, 1};

    for (int i = 0; i < 18; i++) begin
      cmd_valid = tbl[i].cv; cmd_ctl = tbl[i].cc;
      rx_valid = tbl[i].rv; rx_alu = tbl[i].ra; rx_carry = tbl[i].rc; rx_zero = tbl[i].rz;
      m_ready = tbl[i].mr;
      cyc();
      chk($sformatf("v%0d_m_valid", i), m_valid, tbl[i].e_mv);
      chk($sformatf("v%0d_level", i), fifo_level, tbl[i].e_lvl);
      chk($sformatf("v%0d_ctl", i), ctl, tbl[i].e_ctl);
      chk($sformatf("v%0d_cmd_ready", i), cmd_ready, tbl[i].e_crdy);
      if (tbl[i].e_mv) begin
        chk($sformatf("v%0d_m_alu", i), m_alu, tbl[i].e_alu);
        chk($sformatf("v%0d_m_carry", i), m_carry, tbl[i].e_carry);
        chk($sformatf("v%0d_m_zero", i), m_zero, tbl[i].e_mz);
      end
    end
    idle_inputs();
    chk("tbl_zero_err", zero_err, 0);
    chk("tbl_ovf", ovf, 0);

    // Overflow: five fires into a four-deep FIFO with no pops.
    for (int i = 1; i <= 5; i++) begin
      rx_valid = 1; rx_alu = 4'(i); rx_zero = 1;
      cyc();
      chk($sformatf("ovf_level_%0d", i), fifo_level, (i > 4) ? 4 : i);
      chk($sformatf("ovf_flag_%0d", i), ovf, (i == 5) ? 1 : 0);
    end
    rx_valid = 0;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("ovf_drain_alu_%0d", i), m_alu, i);
      m_ready = 1;
      cyc();
    end
    m_ready = 0;
    chk("ovf_drain_empty", m_valid, 0);
    chk("ovf_sticky", ovf, 1);

    // Full FIFO with simultaneous push and pop.
    do_reset();
    chk("reset_clears_ovf", ovf, 0);
    do_cmd(4'd3);
    for (int i = 1; i <= 4; i++) begin
      rx_valid = 1; rx_alu = 4'(i); rx_zero = 1;
      cyc();
    end
    chk("full_level", fifo_level, 4);
    rx_valid = 1; rx_alu = 4'd6; rx_zero = 1; m_ready = 1;
    cyc();
    rx_valid = 0; m_ready = 0;
    chk("pushpop_full_level", fifo_level, 4);
    chk("pushpop_full_ovf", ovf, 0);
    chk("pushpop_full_head", m_alu, 2);
    begin
      int exp_order [4];
      exp_order[0] = 2; exp_order[1] = 3; exp_order[2] = 4; exp_order[3] = 6;
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("pushpop_order_%0d", i), m_alu, exp_order[i]);
        m_ready = 1;
        cyc();
      end
    end
    m_ready = 0;
    chk("pushpop_drained", m_valid, 0);

    // Illegal opcodes leave ctl and state alone.
    cmd_valid = 1; cmd_ctl = 4'hF;
    cyc();
    cmd_valid = 0;
    chk("ill15_pulse", illegal_ctl, 1);
    chk("ill15_ctl", ctl, 3);
    chk("ill15_cmd_ready", cmd_ready, 1);
    rx_valid = 1; rx_alu = 4'd7; rx_zero = 1;
    cyc();
    rx_valid = 0;
    chk("ill15_pulse_end", illegal_ctl, 0);
    chk("ill15_still_active", fifo_level, 1);
    cmd_valid = 1; cmd_ctl = 4'hE; m_ready = 1;
    cyc();
    cmd_valid = 0; m_ready = 0;
    chk("ill14_pulse", illegal_ctl, 1);
    chk("ill14_ctl", ctl, 3);
    chk("ill14_popped", fifo_level, 0);
    cyc();
    chk("ill14_pulse_end", illegal_ctl, 0);

    // Highest legal opcode is accepted and drains.
    cmd_valid = 1; cmd_ctl = 4'd13;
    cyc();
    cmd_valid = 0;
    chk("ctl13_ctl", ctl, 13);
    chk("ctl13_cmd_ready", cmd_ready, 0);
    chk("ctl13_no_illegal", illegal_ctl, 0);
    cyc(); cyc();
    chk("ctl13_active", cmd_ready, 1);

    // Zero-flag mismatch is sticky and the word is still stored.
    rx_valid = 1; rx_alu = 4'd0; rx_zero = 1;
    cyc();
    chk("zerr_set", zero_err, 1);
    chk("zerr_stored_level", fifo_level, 1);
    chk("zerr_stored_mzero", m_zero, 0);
    rx_alu = 4'd3; rx_zero = 1;
    cyc();
    rx_valid = 0;
    chk("zerr_sticky", zero_err, 1);
    chk("zerr_level2", fifo_level, 2);

    // Asynchronous reset mid-cycle with two entries held.
    #2 reset = 1;
    #1;
    chk("areset_level", fifo_level, 0);
    chk("areset_m_valid", m_valid, 0);
    chk("areset_m_alu", m_alu, 0);
    chk("areset_zero_err", zero_err, 0);
    chk("areset_ovf", ovf, 0);
    chk("areset_ctl", ctl, 0);
    chk("areset_cmd_ready", cmd_ready, 1);
    reset = 0;
    rx_valid = 1; rx_alu = 4'd5; rx_zero = 1;
    cyc();
    rx_valid = 0;
    chk("areset_idle_no_capture", fifo_level, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dp_sink.md
# dp_sink

Receive-side endpoint of the DP source link. Issues the 4-bit `ctl` opcode to the source, decodes the source's per-opcode `valid` and `zero` encoding, and captures result words into a small FIFO. It presents those words downstream on a valid/ready stream. It also detects protocol faults: illegal opcodes, inconsistent zero flags and FIFO overflow.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries (power of two, ≥2).
- `DRAIN_CYCLES`, 2: cycles captures stay suppressed after a `ctl` change.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  new opcode request.
- `cmd_ctl`  in  4  requested opcode.
- `cmd_ready`  out  1  opcode request accepted this cycle when `cmd_valid` is also high.
- `ctl`  out  4  opcode driven to the source.
- `rx_valid`  in  1  source valid (encoded, see Operation).
- `rx_alu`  in  4  source result[3:0].
- `rx_carry`  in  1  source result[4].
- `rx_zero`  in  1  source zero flag (encoded).
- `m_valid`  out  1  FIFO head valid.
- `m_ready`  in  1  downstream accepts head.
- `m_alu`  out  4  head result.
- `m_carry`  out  1  head carry.
- `m_zero`  out  1  head true-zero (1 = alu is 0).
- `fifo_level`  out  $clog2(DEPTH)+1  occupancy.
- `ovf`  out  1  sticky: capture dropped while full.
- `illegal_ctl`  out  1  one-cycle pulse: rejected opcode.
- `zero_err`  out  1  sticky: zero-flag encoding mismatch.

## Operation
- States:
  - IDLE (after reset; captures disabled).
  - DRAIN (captures disabled; counter running).
  - ACTIVE (captures enabled).
- `cmd_ready` = 1 in IDLE and ACTIVE, 0 in DRAIN.
- Command accept with `cmd_ctl` ≤ 4'b1101:
  - `ctl` ← `cmd_ctl`.
  - Enter DRAIN with count = `DRAIN_CYCLES`-1.
  - DRAIN counts down and moves to ACTIVE after count 0. This gives `DRAIN_CYCLES` cycles in DRAIN.
  - Re-issuing the current opcode still drains.
- Command accept with `cmd_ctl` ≥ 4'b1110:
  - `illegal_ctl` pulses for 1 cycle.
  - `ctl` and state are unchanged.
- Valid decode: `rx_fire` = `rx_valid` XOR (`ctl`==4'b1001). In XOR mode the source inverts valid.
- Capture: in ACTIVE with `rx_fire`=1, push {`rx_carry`, `rx_alu`, ~`rx_zero`}. The source's zero flag means "alu non-zero"; the sink stores true-zero.
- Zero check: on every capture, if `rx_zero` ≠ |`rx_alu`, set `zero_err`. The word is still stored.
- FIFO behaviour:
  - `m_valid` = level ≠ 0; the head is driven directly from storage.
  - Pop on `m_valid` & `m_ready`.
  - Push while full and not popping: word dropped, `ovf` set.
  - Push and pop together while full: both occur, level unchanged, no overflow.
  - Push and pop together while empty: push only (m_valid was 0).
  - Pointers wrap modulo `DEPTH`.
- A `ctl` change does not flush the FIFO; already-captured words remain.

## Timing
- Reset values:
  - `ctl`=0, state=IDLE, `cmd_ready`=1.
  - `m_valid`=0, `m_alu`=0, `m_carry`=0, `m_zero`=0.
  - `fifo_level`=0, `ovf`=0, `illegal_ctl`=0, `zero_err`=0.
- Reset asserted mid-operation empties the FIFO, clears all flags and returns to IDLE immediately (asynchronously).
- Command accepted at edge k:
  - `ctl` is new after k.
  - `cmd_ready`=0 for cycles k+1…k+`DRAIN_CYCLES`.
  - The first capturable edge is k+`DRAIN_CYCLES`+1.
- Capture latency: `rx_*` sampled at edge k yields `m_valid`=1 and head data after edge k when the FIFO was empty.
- Pop at edge k: the next head or `m_valid`=0 appears after edge k.
- `fifo_level`, `ovf` and `zero_err` update on the same edge as the push or pop.

## Structure
- `dp_pkg`:
  - ctl opcode localparams (`CTL_PASS_A`=0 … `CTL_ROT_C`=13; `CTL_XOR`=9, `CTL_SUB_C`=6).
  - `CTL_MAX`=13.
  - State enum {IDLE, DRAIN, ACTIVE}.
  - Packed struct `dp_word_t` {carry, alu[3:0], zero}.
- One sub-module: `dp_sink_fifo` (parameterised `DEPTH`, `dp_word_t` storage, push/pop/full/empty/level).
- The FSM, decode and flags live in `dp_sink`.

## Test plan
- Reset, then `cmd_ctl`=4'b0011 accepted; `rx_valid`=1 for 3 cycles starting 1 cycle after DRAIN ends, with alu=5,0,9 and zero encoded 1,0,1 -> `m_valid`, words alu 5/0/9 with `m_zero` 0/1/0, `fifo_level` 3, `zero_err`=0.
- `cmd_ctl`=4'b1001, then `rx_valid`=0 with alu=4'hA -> captured (inverted valid); `rx_valid`=1 -> not captured.
- `m_ready`=0 with 5 fires (DEPTH=4) -> level 4, `ovf`=1 after the 5th, and the first 4 words are intact on drain.
- FIFO full with a simultaneous fire and `m_ready`=1 -> level stays 4, `ovf` stays 0, order preserved.
- `cmd_ctl`=4'b1111 -> `illegal_ctl` pulses 1 cycle, `ctl` unchanged, state unchanged.
- `rx_alu`=0 with `rx_zero`=1 -> `zero_err`=1 (sticky). Reset asserted while 2 entries are held -> level 0, `m_valid`=0, flags 0, state IDLE.
